prism_cfg_loader: RTL and testbench

- Upstream feeder for the PRISM configuration latch chain (the DEPTH-deep, WIDTH-bit transparent-latch shift register).
- Accepts 32-bit host-bus writes, assembles a WIDTH-bit config word in a staging flop, then drives the chain's shared data input and per-stage latch enables.
- Enables are non-overlapping one-hot pulses, issued deepest stage first, so each word shifts in hazard-free.
- Tracks how many words have been loaded and flags writes dropped while busy.

---
 rtl/prism_cfg_pkg.sv | 17 +
 rtl/prism_cfg_pulse_seq.sv | 90 +++++++++
 rtl/prism_cfg_loader.sv | 104 ++++++++++
 tb/tb_prism_cfg_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prism_cfg_pkg.sv
// Shared types and constants for the PRISM configuration loader.
package prism_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } cfg_state_t;

    localparam int CFG_WIDTH = 48;
    localparam int CFG_DEPTH = 8;

    localparam logic CFG_ADDR_LO = 1'b0;
    localparam logic CFG_ADDR_HI = 1'b1;

endpackage

// File: rtl/prism_cfg_pulse_seq.sv
// Countdown sequencer: one-hot latch enables from the deepest stage down to
// stage 0, separated by GAP idle cycles, followed by a one-cycle done pulse.
module prism_cfg_pulse_seq
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = CFG_DEPTH,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic [DEPTH-1:0] latch_en_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = $clog2(GAP + 1);

    cfg_state_t       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [DEPTH-1:0] latch_en_q, latch_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next state; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = PULSE;
                    k_d     = KW'(DEPTH - 1);
                end
            end
            PULSE: begin
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = prism_cfg_pkg::GAP;
                    gap_d   = GW'(GAP - 1);
                end
            end
            prism_cfg_pkg::GAP: begin
                if (gap_q == '0) begin
                    state_d = PULSE;
                    k_d     = k_q - KW'(1);
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        latch_en_d = (state_d == PULSE) ? (DEPTH'(1) << k_d) : '0;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any sequence immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            gap_q      <= '0;
            latch_en_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            gap_q      <= gap_d;
            latch_en_q <= latch_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign latch_en_o = latch_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/prism_cfg_loader.sv
// Host-write front end for the PRISM config latch chain: stages a WIDTH-bit
// word from two 32-bit writes, commits it to cfg_data and runs the shift sequence.
module prism_cfg_loader
    import prism_cfg_pkg::*;
#(
    parameter int WIDTH = CFG_WIDTH,
    parameter int DEPTH = CFG_DEPTH,
    parameter int GAP   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_addr,
    input  logic [31:0]                wr_data,
    input  logic                       clr,
    output logic [WIDTH-1:0]           cfg_data,
    output logic [DEPTH-1:0]           latch_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] word_cnt,
    output logic                       ovf
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] cfg_q, cfg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             seq_busy, seq_done;
    logic             lo_wr, hi_wr, drop;

    // The sequencer's busy covers PULSE, GAP and DONE, so it alone gates writes.
    assign lo_wr = wr_en && !seq_busy && (wr_addr == CFG_ADDR_LO);
    assign hi_wr = wr_en && !seq_busy && (wr_addr == CFG_ADDR_HI);
    assign drop  = wr_en && seq_busy;

    generate
        if (WIDTH < 64) begin : g_unused_hi
            logic unused_hi_bits;
            assign unused_hi_bits = ^wr_data[31:WIDTH-32];
        end
    endgenerate

    // Staging, commit, word counter and sticky overflow; clr has priority over both counters.
    always_comb begin
        stage_d = stage_q;
        if (lo_wr) begin
            stage_d[31:0] = wr_data;
        end
        if (hi_wr) begin
            stage_d[WIDTH-1:32] = wr_data[WIDTH-33:0];
        end
        cfg_d = hi_wr ? stage_d : cfg_q;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (seq_done && (cnt_q != CW'(DEPTH))) begin
            cnt_d = cnt_q + CW'(1);
        end

        ovf_d = ovf_q;
        if (clr) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Registered datapath and status state.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    prism_cfg_pulse_seq #(
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (hi_wr),
        .latch_en_o (latch_en),
        .busy_o     (seq_busy),
        .done_o     (seq_done)
    );

    assign cfg_data = cfg_q;
    assign busy     = seq_busy;
    assign done     = seq_done;
    assign word_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Bench for prism_cfg_loader: default instance (48/8/1) and a GAP=3, DEPTH=4 instance.
module tb_prism_cfg_loader;

    logic        clk;
    logic        rst;
    logic        wr_en, wr_addr, clr;
    logic [31:0] wr_data;
    logic [47:0] cfg_data;
    logic [7:0]  latch_en;
    logic        busy, done, ovf;
    logic [3:0]  word_cnt;

    logic        b_wr_en, b_wr_addr, b_clr;
    logic [31:0] b_wr_data;
    logic [47:0] b_cfg_data;
    logic [3:0]  b_latch_en;
    logic        b_busy, b_done, b_ovf;
    logic [2:0]  b_word_cnt;

    int passed = 0;
    int total  = 0;
    int en_cnt = 0;
    logic mon_en = 1'b0;
    logic [47:0] sb[$];
    logic [47:0] chain [8];

    typedef struct {
        logic        use_lo;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [47:0] exp_cfg;
    } ld_t;
    ld_t tbl [9];

    prism_cfg_loader #(.WIDTH(48), .DEPTH(8), .GAP(1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .cfg_data(cfg_data), .latch_en(latch_en), .busy(busy),
        .done(done), .word_cnt(word_cnt), .ovf(ovf)
    );

    prism_cfg_loader #(.WIDTH(48), .DEPTH(4), .GAP(3)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .clr(b_clr), .cfg_data(b_cfg_data), .latch_en(b_latch_en), .busy(b_busy),
        .done(b_done), .word_cnt(b_word_cnt), .ovf(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lo(input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 1'b0; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_hi(input logic [31:0] d, input logic [47:0] exp);
        sb.push_back(exp);
        wr_en = 1'b1; wr_addr = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Monitor: one-hot check, enable count, shift-chain model and scoreboard at done.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            assert ($onehot0(latch_en) && $onehot0(b_latch_en)) passed++;
            else $display("FAIL onehot: latch_en=%h b_latch_en=%h, required one-hot-or-zero",
                          latch_en, b_latch_en);
            if (latch_en != 8'h00) en_cnt++;
            for (int k = 7; k >= 1; k--) if (latch_en[k]) chain[k] = chain[k-1];
            if (latch_en[0]) chain[0] = cfg_data;
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL sb_empty: done with cfg_data=%h, no expected word queued", cfg_data);
                end else begin
                    chk("sb_cfg", 64'(cfg_data), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        tbl[0] = '{1'b0, 32'h0, 32'h0000_1111, 48'h1111_DEADBEEF};
        tbl[1] = '{1'b0, 32'h0, 32'hABCD_2222, 48'h2222_DEADBEEF};
        tbl[2] = '{1'b0, 32'h0, 32'h0000_3333, 48'h3333_DEADBEEF};
        tbl[3] = '{1'b0, 32'h0, 32'hFFFF_4444, 48'h4444_DEADBEEF};
        tbl[4] = '{1'b0, 32'h0, 32'h0000_5555, 48'h5555_DEADBEEF};
        tbl[5] = '{1'b0, 32'h0, 32'h1234_6666, 48'h6666_DEADBEEF};
        tbl[6] = '{1'b0, 32'h0, 32'h0000_7777, 48'h7777_DEADBEEF};
        tbl[7] = '{1'b0, 32'h0, 32'h0000_8888, 48'h8888_DEADBEEF};
        tbl[8] = '{1'b1, 32'h0BAD_F00D, 32'h0000_9999, 48'h9999_0BADF00D};
        for (int k = 0; k < 8; k++) chain[k] = '0;

        rst = 1'b1; wr_en = 1'b0; wr_addr = 1'b0; wr_data = '0; clr = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = 1'b0; b_wr_data = '0; b_clr = 1'b0;
        tick(); tick();
        chk("rst_cfg", 64'(cfg_data), 64'(0));
        chk("rst_latch", 64'(latch_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cnt", 64'(word_cnt), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_b_busy", 64'(b_busy), 64'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Basic load with exact cycle timing.
        do_lo(32'hDEAD_BEEF);
        do_hi(32'h0000_CAFE, 48'hCAFE_DEADBEEF);
        chk("basic_cfg", 64'(cfg_data), 64'h0000_CAFE_DEADBEEF);
        for (int c = 1; c <= 17; c++) begin
            logic [7:0] e;
            e = ((c % 2) == 1 && c <= 15) ? (8'h80 >> ((c - 1) / 2)) : 8'h00;
            chk($sformatf("basic_latch_c%0d", c), 64'(latch_en), 64'(e));
            chk($sformatf("basic_busy_c%0d", c), 64'(busy), 64'(c <= 16));
            chk($sformatf("basic_done_c%0d", c), 64'(done), 64'(c == 16));
            chk($sformatf("basic_cfgstable_c%0d", c), 64'(cfg_data), 64'h0000_CAFE_DEADBEEF);
            if (c < 17) tick();
        end
        chk("basic_cnt", 64'(word_cnt), 64'(1));

        // Back-to-back table loads, word_cnt saturation and chain contents.
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_cnt", 64'(word_cnt), 64'(0));
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].use_lo) do_lo(tbl[i].lo);
            do_hi(tbl[i].hi, tbl[i].exp_cfg);
            chk($sformatf("tbl_cfg_%0d", i), 64'(cfg_data), 64'(tbl[i].exp_cfg));
            wait_idle();
            chk($sformatf("tbl_cnt_%0d", i), 64'(word_cnt), 64'((i + 1 > 8) ? 8 : i + 1));
            if (i == 7) begin
                for (int k = 0; k < 8; k++)
                    chk($sformatf("chain_%0d", k), 64'(chain[k]), 64'(tbl[7-k].exp_cfg));
            end
        end
        chk("tbl_ovf", 64'(ovf), 64'(0));

        // Overflow: dropped hi write in cycle 5.
        do_hi(32'h0000_AAAA, 48'hAAAA_0BADF00D);
        repeat (4) tick();
        wr_en = 1'b1; wr_addr = 1'b1; wr_data = 32'h0000_BBBB;
        tick();
        wr_en = 1'b0;
        chk("ovf_set", 64'(ovf), 64'(1));
        chk("ovf_cfg", 64'(cfg_data), 64'h0000_AAAA_0BADF00D);
        chk("ovf_busy", 64'(busy), 64'(1));
        wait_idle();
        chk("ovf_sticky", 64'(ovf), 64'(1));
        chk("ovf_cnt", 64'(word_cnt), 64'(8));

        // clr together with a dropped lo write.
        do_hi(32'h0000_CCCC, 48'hCCCC_0BADF00D);
        repeat (2) tick();
        wr_en = 1'b1; wr_addr = 1'b0; wr_data = 32'h1234_5678; clr = 1'b1;
        tick();
        wr_en = 1'b0; clr = 1'b0;
        chk("clrdrop_ovf", 64'(ovf), 64'(0));
        chk("clrdrop_cnt", 64'(word_cnt), 64'(0));
        wait_idle();
        do_hi(32'h0000_DDDD, 48'hDDDD_0BADF00D);
        chk("droplo_cfg", 64'(cfg_data), 64'h0000_DDDD_0BADF00D);
        wait_idle();
        chk("droplo_cnt", 64'(word_cnt), 64'(2));

        // Reset in cycle 6 of a sequence.
        do_hi(32'h0000_EEEE, 48'hEEEE_0BADF00D);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        en_cnt = 0;
        sb.delete();
        chk("midrst_cfg", 64'(cfg_data), 64'(0));
        chk("midrst_latch", 64'(latch_en), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_cnt", 64'(word_cnt), 64'(0));
        chk("midrst_ovf", 64'(ovf), 64'(0));
        rst = 1'b0;
        repeat (20) tick();
        chk("midrst_no_en", 64'(en_cnt), 64'(0));
        chk("midrst_idle", 64'(busy), 64'(0));
        do_hi(32'h0000_1234, 48'h1234_00000000);
        chk("postrst_cfg", 64'(cfg_data), 64'h0000_1234_00000000);
        wait_idle();
        chk("postrst_en", 64'(en_cnt), 64'(8));
        chk("postrst_cnt", 64'(word_cnt), 64'(1));

        // clr coinciding with DONE, then a lo-only write starts nothing.
        do_lo(32'h5555_AAAA);
        do_hi(32'h0000_0042, 48'h0042_5555AAAA);
        repeat (15) tick();
        chk("clrdone_done", 64'(done), 64'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrdone_cnt", 64'(word_cnt), 64'(0));
        chk("clrdone_busy", 64'(busy), 64'(0));
        do_lo(32'hFFFF_0000);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("loonly_busy_%0d", c), 64'(busy), 64'(0));
            chk($sformatf("loonly_latch_%0d", c), 64'(latch_en), 64'(0));
            tick();
        end

        // GAP=3, DEPTH=4 instance timing.
        b_wr_en = 1'b1; b_wr_addr = 1'b0; b_wr_data = 32'h1111_2222;
        tick();
        b_wr_addr = 1'b1; b_wr_data = 32'h0000_3333;
        tick();
        b_wr_en = 1'b0;
        chk("b_cfg", 64'(b_cfg_data), 64'h0000_3333_11112222);
        for (int c = 1; c <= 15; c++) begin
            logic [3:0] e;
            e = ((c % 4) == 1 && c <= 13) ? (4'h8 >> ((c - 1) / 4)) : 4'h0;
            chk($sformatf("b_latch_c%0d", c), 64'(b_latch_en), 64'(e));
            chk($sformatf("b_done_c%0d", c), 64'(b_done), 64'(c == 14));
            chk($sformatf("b_busy_c%0d", c), 64'(b_busy), 64'(c <= 14));
            if (c < 15) tick();
        end
        chk("b_cnt", 64'(b_word_cnt), 64'(1));
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
